// File: rtl/rb_sequencer.sv
// Microprogram sequencer for the 16x8 register bank and ALU: fetches 16-bit
// instructions from a synchronous ROM and decodes them into RB/ALU controls.
module rb_sequencer #(
    parameter int unsigned PC_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WDOG_LIMIT = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [15:0]           imem_data,
    input  logic                  alu_zero,
    output logic [3:0]            alu_op,
    output logic [2:0]            rb_in_mux,
    output logic [3:0]            rb_out_mux,
    output logic [3:0]            rb_reg_add,
    output logic                  rb_we,
    output logic [DATA_WIDTH-1:0] rb_const
);

    localparam int unsigned WDOG_WIDTH = $clog2(WDOG_LIMIT + 1);

    localparam logic [2:0] OP_LDI  = 3'd1;
    localparam logic [2:0] OP_MOV  = 3'd2;
    localparam logic [2:0] OP_IN   = 3'd3;
    localparam logic [2:0] OP_ALU  = 3'd4;
    localparam logic [2:0] OP_JNZ  = 3'd5;
    localparam logic [2:0] OP_JMP  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} stateType;

    stateType              state;
    stateType              nextState;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   pcNext;
    logic [WDOG_WIDTH-1:0] wdog;
    logic                  wdogExpired;
    logic [2:0]            opcode;
    logic [3:0]            regField;
    logic [3:0]            srcField;
    logic [7:0]            konst;
    logic                  unusedBits;

    assign opcode      = imem_data[15:13];
    assign regField    = imem_data[11:8];
    assign srcField    = imem_data[7:4];
    assign konst       = imem_data[7:0];
    assign unusedBits  = imem_data[12];
    assign wdogExpired = (wdog == WDOG_WIDTH'(WDOG_LIMIT - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; the watchdog lets the final instruction complete first
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = FETCH;
            FETCH:   nextState = EXEC;
            EXEC:    nextState = (opcode == OP_HALT || wdogExpired) ? DONE : FETCH;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Branch target selection; jump targets take the low PC bits of k
    always_comb begin
        pcNext = pc + PC_WIDTH'(1);
        case (opcode)
            OP_JNZ:  if (!alu_zero) pcNext = PC_WIDTH'(konst);
            OP_JMP:  pcNext = PC_WIDTH'(konst);
            default: pcNext = pc + PC_WIDTH'(1);
        endcase
    end

    // Program counter, watchdog and sticky abort flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            wdog  <= '0;
            error <= 1'b0;
        end else if (state == IDLE && start) begin
            pc    <= '0;
            wdog  <= '0;
            error <= 1'b0;
        end else if (state == EXEC) begin
            wdog <= wdog + WDOG_WIDTH'(1);
            if (opcode != OP_HALT) begin
                pc <= pcNext;
                if (wdogExpired) error <= 1'b1;
            end
        end
    end

    // Status outputs and instruction decode, live only during EXEC
    always_comb begin
        busy       = (state == FETCH) || (state == EXEC);
        done       = (state == DONE);
        imem_addr  = pc;
        alu_op     = 4'd0;
        rb_in_mux  = 3'd0;
        rb_out_mux = 4'd0;
        rb_reg_add = 4'd0;
        rb_we      = 1'b0;
        rb_const   = '0;
        if (state == EXEC) begin
            case (opcode)
                OP_LDI: begin
                    rb_in_mux  = 3'd2;
                    rb_const   = DATA_WIDTH'(konst);
                    rb_reg_add = regField;
                    rb_we      = 1'b1;
                end
                OP_MOV: begin
                    rb_in_mux  = 3'd4;
                    rb_out_mux = srcField;
                    rb_reg_add = regField;
                    rb_we      = 1'b1;
                end
                OP_IN: begin
                    rb_in_mux  = {2'b00, imem_data[0]};
                    rb_reg_add = regField;
                    rb_we      = 1'b1;
                end
                OP_ALU: begin
                    alu_op     = imem_data[3:0];
                    rb_in_mux  = 3'd3;
                    rb_reg_add = regField;
                    rb_we      = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rb_sequencer.sv
// Bench for rb_sequencer: ROM and register-bank environment plus an
// instruction-level model that predicts every cycle of each program run.
module tb_rb_sequencer;

    localparam int unsigned WDOG = 10;
    localparam logic [7:0] IN_A = 8'h11;
    localparam logic [7:0] IN_B = 8'h22;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        alu_zero;
    logic [3:0]  alu_op;
    logic [2:0]  rb_in_mux;
    logic [3:0]  rb_out_mux;
    logic [3:0]  rb_reg_add;
    logic        rb_we;
    logic [7:0]  rb_const;

    rb_sequencer #(.PC_WIDTH(8), .DATA_WIDTH(8), .WDOG_LIMIT(WDOG)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .error(error), .imem_addr(imem_addr), .imem_data(imem_data),
        .alu_zero(alu_zero), .alu_op(alu_op), .rb_in_mux(rb_in_mux),
        .rb_out_mux(rb_out_mux), .rb_reg_add(rb_reg_add), .rb_we(rb_we),
        .rb_const(rb_const)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] aluFn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return a;
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a - 8'd1;
            default: return a ^ b;
        endcase
    endfunction

    // Environment: synchronous ROM, register bank and ALU on regs 1,2
    logic [15:0] rom [256];
    logic [7:0]  envRegs [16];
    logic [7:0]  aluOut;

    always @(posedge clk) imem_data <= rom[imem_addr];

    always_comb aluOut = aluFn(alu_op, envRegs[1], envRegs[2]);
    assign alu_zero = (aluOut == 8'd0);

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) envRegs[i] <= 8'd0;
        end else if (rb_we) begin
            case (rb_in_mux)
                3'd0:    envRegs[rb_reg_add] <= IN_A;
                3'd1:    envRegs[rb_reg_add] <= IN_B;
                3'd2:    envRegs[rb_reg_add] <= rb_const;
                3'd3:    envRegs[rb_reg_add] <= aluOut;
                3'd4:    envRegs[rb_reg_add] <= envRegs[rb_out_mux];
                default: envRegs[rb_reg_add] <= 8'hEE;
            endcase
        end
    end

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       error;
        logic       addrChk;
        logic [7:0] addr;
        logic       we;
        logic [2:0] inMux;
        logic [3:0] outMux;
        logic [3:0] regAdd;
        logic [7:0] konst;
        logic [3:0] aluOp;
    } expT;

    expT  expQ[$];
    expT  ce;
    expT  ca;
    int   nTests;
    int   nFail;
    int   lastLen;
    int   cyc;
    logic mErr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic loadRom(input logic [15:0] prog[$]);
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        foreach (prog[i]) rom[i] = prog[i];
    endtask

    // Instruction-level interpreter: one FETCH and one EXEC cycle per instruction
    task automatic buildExp(input bit lead);
        logic [7:0]  mr [16];
        logic [7:0]  pc;
        logic [7:0]  pcN;
        logic [7:0]  k;
        logic [15:0] ins;
        logic [3:0]  r;
        logic [3:0]  s;
        int          w;
        bit          fin;
        expT         e;
        for (int i = 0; i < 16; i++) mr[i] = envRegs[i];
        expQ.delete();
        if (lead) begin
            e = '0;
            e.error = mErr;
            expQ.push_back(e);
        end
        mErr = 1'b0;
        pc   = 8'd0;
        w    = 0;
        fin  = 1'b0;
        while (!fin) begin
            e = '0;
            e.busy = 1'b1;
            e.addrChk = 1'b1;
            e.addr = pc;
            expQ.push_back(e);
            ins = rom[pc];
            r   = ins[11:8];
            s   = ins[7:4];
            k   = ins[7:0];
            pcN = pc + 8'd1;
            e = '0;
            e.busy = 1'b1;
            case (ins[15:13])
                3'd1: begin e.we = 1'b1; e.inMux = 3'd2; e.konst = k; e.regAdd = r; mr[r] = k; end
                3'd2: begin e.we = 1'b1; e.inMux = 3'd4; e.outMux = s; e.regAdd = r; mr[r] = mr[s]; end
                3'd3: begin
                    e.we = 1'b1; e.inMux = {2'b00, ins[0]}; e.regAdd = r;
                    mr[r] = ins[0] ? IN_B : IN_A;
                end
                3'd4: begin
                    e.we = 1'b1; e.inMux = 3'd3; e.aluOp = ins[3:0]; e.regAdd = r;
                    mr[r] = aluFn(ins[3:0], mr[1], mr[2]);
                end
                3'd5: if (aluFn(4'd0, mr[1], mr[2]) != 8'd0) pcN = k;
                3'd6: pcN = k;
                default: ;
            endcase
            expQ.push_back(e);
            w++;
            if (ins[15:13] == 3'd7) begin
                e = '0; e.done = 1'b1;
                expQ.push_back(e);
                fin = 1'b1;
            end else if (w == int'(WDOG)) begin
                mErr = 1'b1;
                e = '0; e.done = 1'b1; e.error = 1'b1;
                expQ.push_back(e);
                fin = 1'b1;
            end else begin
                pc = pcN;
            end
        end
        e = '0;
        e.error = mErr;
        expQ.push_back(e);
        lastLen = expQ.size();
    endtask

    // hold: leave start high afterwards; cont: start was already held into this run
    task automatic runProg(input bit hold, input bit cont);
        int n;
        if (!cont) begin
            @(posedge clk);
            #1;
            buildExp(1'b1);
            start = 1'b1;
            @(posedge clk);
            #1;
        end else begin
            #1;
            buildExp(1'b0);
        end
        if (!hold) start = 1'b0;
        n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            nTests++;
            nFail++;
            $display("FAIL run_timeout: %0d expected cycles left, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    initial begin
        nTests = 0;
        nFail  = 0;
        cyc    = 0;
        mErr   = 1'b0;
        reset  = 1'b1;
        start  = 1'b0;
        loadRom('{16'hE000});
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_error", 32'(error), 32'd0);
        chk("reset_addr", 32'(imem_addr), 32'd0);
        chk("reset_rb", 32'({alu_op, rb_in_mux, rb_out_mux, rb_reg_add, rb_const, rb_we}), 32'd0);

        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (expQ.size() != 0) begin
                    ce = expQ.pop_front();
                    ca.busy    = busy;
                    ca.done    = done;
                    ca.error   = error;
                    ca.addrChk = ce.addrChk;
                    ca.addr    = ce.addrChk ? imem_addr : 8'd0;
                    ca.we      = rb_we;
                    ca.inMux   = rb_in_mux;
                    ca.outMux  = rb_out_mux;
                    ca.regAdd  = rb_reg_add;
                    ca.konst   = rb_const;
                    ca.aluOp   = alu_op;
                    nTests++;
                    if (ca !== ce) begin
                        nFail++;
                        $display("FAIL cycle%0d outputs: got %h, required %h (busy,done,err,chk,addr,we,in,out,reg,k,op)",
                                 cyc, ca, ce);
                    end
                end
            end
        join_none

        // LDI r1,5; LDI r2,3; ALU op2 (sub) r0; HALT
        loadRom('{16'h2105, 16'h2203, 16'h8002, 16'hE000});
        runProg(1'b0, 1'b0);
        chk("prog1_len", 32'(lastLen), 32'd11);
        chk("prog1_r0", 32'(envRegs[0]), 32'd2);
        chk("prog1_r1", 32'(envRegs[1]), 32'd5);
        chk("prog1_r2", 32'(envRegs[2]), 32'd3);

        // LDI r3,5A; MOV r4,r3; IN r5 (InB); IN r6 (InA); ALU add r7; NOP; HALT
        loadRom('{16'h235A, 16'h4430, 16'h6501, 16'h6600, 16'h8701, 16'h0000, 16'hE000});
        runProg(1'b0, 1'b0);
        chk("misc_r4", 32'(envRegs[4]), 32'h5A);
        chk("misc_r5", 32'(envRegs[5]), 32'h22);
        chk("misc_r6", 32'(envRegs[6]), 32'h11);
        chk("misc_r7", 32'(envRegs[7]), 32'd8);

        // JNZ 254 (r1!=0); [254] LDI r1,0; [255] NOP wraps to 0; JNZ falls to HALT
        loadRom('{16'hA0FE, 16'hE000});
        rom[254] = 16'h2100;
        rom[255] = 16'h0000;
        runProg(1'b0, 1'b0);
        chk("wrap_len", 32'(lastLen), 32'd13);
        chk("wrap_r1", 32'(envRegs[1]), 32'd0);

        // LDI r1,4; loop: ALU dec r1; JNZ loop; HALT (HALT is the tenth instruction)
        loadRom('{16'h2104, 16'h8103, 16'hA001, 16'hE000});
        runProg(1'b0, 1'b0);
        chk("loop_len", 32'(lastLen), 32'd23);
        chk("loop_r1", 32'(envRegs[1]), 32'd0);
        chk("loop_error", 32'(error), 32'd0);

        // JMP 0 forever: watchdog abort, then a second start clears error
        loadRom('{16'hC000});
        runProg(1'b0, 1'b0);
        chk("wdog_len", 32'(lastLen), 32'd23);
        chk("wdog_error", 32'(error), 32'd1);
        runProg(1'b0, 1'b0);

        // start held through run and done: restart only from IDLE
        loadRom('{16'h2105, 16'h2203, 16'h8002, 16'hE000});
        runProg(1'b1, 1'b0);
        runProg(1'b0, 1'b1);
        chk("held_error", 32'(error), 32'd0);

        // Async reset in the middle of an LDI execute cycle
        loadRom('{16'h2577, 16'hE000});
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_pre_we", 32'({rb_we, rb_reg_add}), 32'h15);
        reset = 1'b1;
        #1;
        chk("rst_we", 32'(rb_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mErr  = 1'b0;

        loadRom('{16'h2105, 16'h2203, 16'h8002, 16'hE000});
        runProg(1'b0, 1'b0);
        chk("post_rst_r0", 32'(envRegs[0]), 32'd2);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
